// File: rtl/des_sbox_engine_if.sv
// des_sbox_engine_if: valid/ready block handshake between a round controller and the S-box engine
interface des_sbox_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_sbox_engine.sv
// des_sbox_engine: DES S1..S8 substitution of a 48-bit round value, LANES boxes per cycle
module des_sbox_engine #(
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst,
    des_sbox_engine_if.slave io
);
    localparam int STEPS = 8 / LANES;
    localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    // One 256-bit table per box, entry row*16+col stored MSB-first; SBOX[7] is S1
    localparam logic [7:0][255:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                st;
    state_t                nxt;
    logic [SW-1:0]         step;
    logic [7:0][5:0]       hold;
    logic [7:0][3:0]       res;
    logic [LANES-1:0][2:0] box;
    logic [LANES-1:0][3:0] nib;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    // Box b (0 = S1) is table SBOX[~b]; entry i sits at bits 255-4i, i.e. {~i, 2'b11}
    function automatic logic [3:0] lookup(input logic [2:0] b, input logic [5:0] x);
        logic [255:0] t;
        t = SBOX[~b];
        return t[{~{x[5], x[0], x[4:1]}, 2'b11} -: 4];
    endfunction

    // Lane j serves box step*LANES+j; box 1 occupies the top slice and top nibble
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            box[j] = 3'(int'(step) * LANES + j);
            nib[j] = lookup(box[j], hold[~box[j]]);
        end
    end

    // IDLE accepts a block, BUSY runs STEPS lookup cycles, DONE holds until the consumer takes it
    always_comb begin
        nxt = st == IDLE ? (io.in_valid ? BUSY : IDLE)
            : st == BUSY ? (step == LAST ? DONE : BUSY)
            : (io.out_ready ? IDLE : DONE);
    end

    // State, holding, step and result registers; reset clears everything so no stale result survives
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            step <= '0;
            hold <= '0;
            res  <= '0;
        end else begin
            st <= nxt;
            if (st == IDLE && io.in_valid) begin
                hold <= io.in_data;
                step <= '0;
            end
            if (st == BUSY) begin
                step <= step == LAST ? '0 : step + 1'b1;
                for (int j = 0; j < LANES; j++) res[~box[j]] <= nib[j];
            end
        end
    end

    assign io.in_ready  = st == IDLE;
    assign io.out_valid = st == DONE;
    assign io.busy      = st == BUSY;
    assign io.out_data  = res;
endmodule

// File: doc/des_sbox_engine.md
Name: des_sbox_engine

Overview:
- Full DES substitution stage: takes the 48-bit post-key-XOR round value, applies S1..S8, and returns the 32-bit result that feeds the P permutation.
- Generalises the single-box combinational lookup to all eight boxes.
- LANES sets how many boxes are looked up per cycle, trading area against latency.
- Valid/ready handshakes on both sides let the round controller stall.

Parameters:
- LANES, default 2: S-box lookups per cycle. Legal values are 1, 2, 4, 8; any other value is an elaboration error.
- STEPS, default 8/LANES: derived locally, not overridable. Number of BUSY cycles per block.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine can accept a new block.
- in_data  in  48  substitution input. Bit 47 is the MSB; box k (1..8) uses in_data[53-6k -: 6].
- out_valid  out  1  out_data holds a complete result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  32  substitution result. Box k drives out_data[35-4k -: 4].
- busy  out  1  high while in BUSY.

Behaviour:
- Lookup rule, per box:
  - row = {b5, b0}, col = b4..b1 of the box's 6-bit slice.
  - Output is the standard FIPS 46-3 table entry for that box.
  - Each lane holds all eight tables and a box-select mux. Lane j in step s serves box s*LANES+j+1.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, capture in_data into a 48-bit holding register, clear step counter to 0, go to BUSY.
  - BUSY: in_ready=0. Each cycle, LANES boxes are looked up from the holding register, and their nibbles are written into the 32-bit result register at their final positions. Step counter increments. On the cycle with step==STEPS-1, go to DONE.
  - DONE: out_valid=1, out_data = result register, held stable until out_ready. On out_ready, go to IDLE; in_ready rises the following cycle.
- in_ready is (state==IDLE) only. Acceptance of in_data is never combinationally dependent on out_ready.
- Latency: block accepted at edge T gives out_valid high after edge T+STEPS.
  - LANES=8: 1 cycle. LANES=1: 8 cycles.
  - Minimum initiation interval is STEPS+1 cycles, with out_ready held high.
- in_data changes while BUSY have no effect, because the holding register is used.
- out_valid is high exactly while in DONE. out_data is defined only while out_valid=1, but must not change during DONE.
- Reset values, asserted at any point including mid-BUSY or DONE with out_ready low:
  - state=IDLE, in_ready=1 the cycle after reset release, out_valid=0, busy=0.
  - Step counter=0, holding and result registers=0, out_data=0.
  - No stale result is ever presented after reset.
- Step counter width is $clog2(STEPS), minimum 1 bit. It never wraps outside BUSY.
- All lookups are pure combinational within one cycle. No multicycle paths.

Test Plan:
- LANES=2, in_data=48'h000000000000 -> out_data=32'hEFA72C4D, out_valid high exactly 4 cycles after acceptance, busy high 4 cycles.
- LANES=2, in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB.
- LANES=2, in_data=48'h002000000000 (S2 slice 6'b000010: row 0, col 1) -> out_data=32'hE1A72C4D, checking S2 nibble=1 and all other nibbles at their zero-input values.
- out_ready held low 10 cycles after out_valid -> out_data stable and in_ready=0 throughout. out_ready pulsed -> out_valid drops next cycle, in_ready=1; a second block accepted immediately completes correctly.
- rst asserted on the 2nd BUSY cycle with in_data=48'hFFFFFFFFFFFF in flight -> next cycle out_valid=0, busy=0, out_data=0, in_ready=1. A new all-zero block then yields 32'hEFA72C4D.
- Repeat the first three scenarios at LANES=1, 4, 8 -> identical out_data, with latency 8, 2, 1 cycles respectively. Random 1000-vector run against a software DES S-box model, with random out_ready backpressure -> zero mismatches.
